// File: rtl/subneg_bus_pkg.sv
//------------------------------------------------------------------------------
// Module  : subneg_bus_pkg
// Purpose : Shared types and constants for the SUBNEG external-bus responder:
//           responder state encoding, bus width, output-port address and the
//           idle (inactive) level of every bus-side strobe.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package subneg_bus_pkg;

  localparam int BUS_W = 8;

  // Address the core uses for its output port; the port itself is strobed by
  // out_clk, so the responder never decodes this value.
  localparam logic [BUS_W-1:0] OUT_PORT_ADDR = 8'hFF;

  // Levels the synchronizers hold in reset so that no edge appears on release.
  localparam logic             LATCH_CLK_IDLE = 1'b0;
  localparam logic             OE_N_IDLE      = 1'b1;
  localparam logic             WE_N_IDLE      = 1'b1;
  localparam logic             OUT_CLK_IDLE   = 1'b0;
  localparam logic [BUS_W-1:0] BUS_IDLE       = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_PROG  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/subneg_mem_responder_if.sv
//------------------------------------------------------------------------------
// Module  : subneg_mem_responder_if
// Purpose : SUBNEG core <-> memory responder bus bundle.
// Signals : bus_in (core data), bus_out/bus_oe (responder read drive),
//           core_bus_oe (core drive enable), latch_clk (address latch),
//           oe_n / we_n (memory strobes, active low), out_clk (output latch).
// Modports: master = core side, slave = responder side.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface subneg_mem_responder_if;
  import subneg_bus_pkg::*;

  logic [BUS_W-1:0] bus_in;
  logic [BUS_W-1:0] bus_out;
  logic             bus_oe;
  logic             core_bus_oe;
  logic             latch_clk;
  logic             oe_n;
  logic             we_n;
  logic             out_clk;

  modport master (
    output bus_in, core_bus_oe, latch_clk, oe_n, we_n, out_clk,
    input  bus_out, bus_oe
  );

  modport slave (
    input  bus_in, core_bus_oe, latch_clk, oe_n, we_n, out_clk,
    output bus_out, bus_oe
  );

endinterface

`default_nettype wire

// File: rtl/subneg_sync_edge.sv
//------------------------------------------------------------------------------
// Module  : subneg_sync_edge
// Purpose : STAGES-deep synchronizer with optional rise/fall detection.
//           Edges are judged between the last synchronizer stage and one
//           extra history register. Reset loads RST_VAL everywhere so no
//           edge is reported right after reset release.
// Ports   : clk, rst_n (async, active low), d_in (asynchronous input),
//           q_sync (synchronized level), rise / fall (one-cycle pulses,
//           tied low when EDGE_EN=0).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module subneg_sync_edge #(
  parameter int               STAGES  = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               EDGE_EN = 1'b1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [WIDTH-1:0] d_in,
  output logic      [WIDTH-1:0] q_sync,
  output logic      [WIDTH-1:0] rise,
  output logic      [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain_q [STAGES];
  logic [WIDTH-1:0] chain_d [STAGES];

  always_comb begin
    chain_d[0] = d_in;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        chain_q[i] <= chain_d[i];
      end
    end
  end

  assign q_sync = chain_q[STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    assign prev_d = q_sync;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev_q <= RST_VAL;
      end else begin
        prev_q <= prev_d;
      end
    end

    assign rise = q_sync & ~prev_q;
    assign fall = ~q_sync & prev_q;
  end else begin : g_no_edge
    assign rise = '0;
    assign fall = '0;
  end

endmodule

`default_nettype wire

// File: rtl/subneg_mem_responder.sv
//------------------------------------------------------------------------------
// Module  : subneg_mem_responder
// Purpose : Memory-side responder for the SUBNEG core bus. Replaces the
//           address latch, SRAM and output latch: latches addresses, serves
//           reads, captures writes and the output-port byte, and accepts
//           program preload through a loader port while prog_en is high.
// Ports   : clk, rst_n (async, active low)
//           bus      - subneg_mem_responder_if.slave (core bus)
//           out_q    - output-port byte
//           prog_en  - loader mode, core strobes ignored while high
//           ld_valid/ld_ready/ld_addr/ld_data - loader write channel
//           err      - sticky: out-of-range access or bus contention
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module subneg_mem_responder
  import subneg_bus_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  subneg_mem_responder_if.slave bus,
  output logic [BUS_W-1:0]      out_q,
  input  wire logic             prog_en,
  input  wire logic             ld_valid,
  output logic                  ld_ready,
  input  wire logic [BUS_W-1:0] ld_addr,
  input  wire logic [BUS_W-1:0] ld_data,
  output logic                  err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic in_range(input logic [BUS_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic [AW-1:0] to_idx(input logic [BUS_W-1:0] a);
    return a[AW-1:0];
  endfunction

  // ---------------- synchronizers ----------------
  logic             latch_rise, latch_fall_unused;
  logic             oe_n_s, oe_rise_unused, oe_fall_unused;
  logic             we_fall, we_rise_unused;
  logic             out_rise, out_fall_unused;
  logic [BUS_W-1:0] bus_s, bus_rise_unused, bus_fall_unused;
  logic             latch_s_unused, we_s_unused, out_s_unused;

  subneg_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(LATCH_CLK_IDLE), .EDGE_EN(1'b1))
    u_sync_latch (.clk(clk), .rst_n(rst_n), .d_in(bus.latch_clk),
                  .q_sync(latch_s_unused), .rise(latch_rise), .fall(latch_fall_unused));

  subneg_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(OE_N_IDLE), .EDGE_EN(1'b1))
    u_sync_oe (.clk(clk), .rst_n(rst_n), .d_in(bus.oe_n),
               .q_sync(oe_n_s), .rise(oe_rise_unused), .fall(oe_fall_unused));

  subneg_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(WE_N_IDLE), .EDGE_EN(1'b1))
    u_sync_we (.clk(clk), .rst_n(rst_n), .d_in(bus.we_n),
               .q_sync(we_s_unused), .rise(we_rise_unused), .fall(we_fall));

  subneg_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(OUT_CLK_IDLE), .EDGE_EN(1'b1))
    u_sync_out (.clk(clk), .rst_n(rst_n), .d_in(bus.out_clk),
                .q_sync(out_s_unused), .rise(out_rise), .fall(out_fall_unused));

  // Same depth as the strobes so the data sampled on an edge is the data that
  // accompanied that edge on the raw bus.
  subneg_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(BUS_W), .RST_VAL(BUS_IDLE), .EDGE_EN(1'b0))
    u_sync_bus (.clk(clk), .rst_n(rst_n), .d_in(bus.bus_in),
                .q_sync(bus_s), .rise(bus_rise_unused), .fall(bus_fall_unused));

  // ---------------- state ----------------
  logic [BUS_W-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [BUS_W-1:0] addr_q, addr_d;
  logic [BUS_W-1:0] bus_out_q, bus_out_d;
  logic             bus_oe_q, bus_oe_d;
  logic [BUS_W-1:0] out_byte_q, out_byte_d;
  logic             ld_ready_q, ld_ready_d;
  logic             err_q, err_d;

  logic strobes_live;
  logic wr_bus;
  logic ld_xfer;

  always_comb begin
    // prog_en is used raw so loader mode takes effect on the next edge.
    strobes_live = !prog_en && (state_q != S_PROG);
    wr_bus       = strobes_live && we_fall;
    ld_xfer      = ld_valid && ld_ready_q;

    addr_d = addr_q;
    if (strobes_live && latch_rise) begin
      addr_d = bus_s;
    end

    out_byte_d = out_byte_q;
    if (strobes_live && out_rise) begin
      out_byte_d = bus_s;
    end

    state_d = state_q;
    if (prog_en) begin
      state_d = S_PROG;
    end else begin
      case (state_q)
        S_IDLE:  if (!oe_n_s) state_d = S_DRIVE;
        S_DRIVE: if (oe_n_s)  state_d = S_IDLE;
        S_PROG:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    bus_oe_d   = (state_d == S_DRIVE);
    ld_ready_d = (state_d == S_PROG);

    // Read data refreshed every DRIVE cycle from the current latched address.
    bus_out_d = '0;
    if (bus_oe_d && in_range(addr_q)) begin
      bus_out_d = mem[to_idx(addr_q)];
    end

    err_d = err_q
          | (bus_oe_d && !in_range(addr_q))
          | (wr_bus   && !in_range(addr_q))
          | (ld_xfer  && !in_range(ld_addr))
          | (bus.core_bus_oe && bus_oe_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      bus_out_q  <= '0;
      bus_oe_q   <= 1'b0;
      out_byte_q <= '0;
      ld_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bus_out_q  <= bus_out_d;
      bus_oe_q   <= bus_oe_d;
      out_byte_q <= out_byte_d;
      ld_ready_q <= ld_ready_d;
      err_q      <= err_d;
    end
  end

  // Storage is not reset. Bus writes and loader writes never coincide since
  // one needs S_PROG and the other forbids it. A write uses addr_q, so a
  // latch edge in the same cycle only affects later accesses.
  always_ff @(posedge clk) begin
    if (wr_bus && in_range(addr_q)) begin
      mem[to_idx(addr_q)] <= bus_s;
    end else if (ld_xfer && in_range(ld_addr)) begin
      mem[to_idx(ld_addr)] <= ld_data;
    end
  end

  assign bus.bus_out = bus_out_q;
  assign bus.bus_oe  = bus_oe_q;
  assign out_q       = out_byte_q;
  assign ld_ready    = ld_ready_q;
  assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_subneg_mem_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_subneg_mem_responder
// Purpose : Self-checking bench for subneg_mem_responder. A transaction-level
//           reference model (memory array, latched address, output byte,
//           driving / loader flags) predicts the outputs every cycle from a
//           delayed history of the raw inputs; directed checks pin the model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_subneg_mem_responder;
  import subneg_bus_pkg::*;

  localparam int DEPTH = 32;
  localparam int SS    = 2;
  localparam int HL    = SS + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_en, ld_valid, ld_ready, err;
  logic [7:0] ld_addr, ld_data, out_q;

  always #5 clk = ~clk;

  subneg_mem_responder_if bif ();

  subneg_mem_responder #(.DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bif),
    .out_q    (out_q),
    .prog_en  (prog_en),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .err      (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] bus;
    logic       latch, oe_n, we_n, outc;
    logic       prog, ldv, core;
    logic [7:0] lda, ldd;
  } samp_t;

  samp_t      hist[$];
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_addr, m_outq, m_bus_out;
  logic       m_bus_oe, m_prog, m_ld_ready, m_err;

  function automatic samp_t take_sample();
    samp_t s;
    s.bus = bif.bus_in; s.latch = bif.latch_clk; s.oe_n = bif.oe_n; s.we_n = bif.we_n;
    s.outc = bif.out_clk; s.prog = prog_en; s.ldv = ld_valid; s.core = bif.core_bus_oe;
    s.lda = ld_addr; s.ldd = ld_data;
    return s;
  endfunction

  function automatic samp_t idle_sample();
    samp_t s;
    s = '0;
    s.oe_n = 1'b1;
    s.we_n = 1'b1;
    return s;
  endfunction

  initial begin : compare
    bit    r, live, nd;
    samp_t cur, raw, syn, prv;
    forever begin
      @(posedge clk);
      r = rst_n;
      @(negedge clk);
      cur = take_sample();
      if (!r || !rst_n) begin
        m_addr = 0; m_outq = 0; m_bus_out = 0;
        m_bus_oe = 0; m_prog = 0; m_ld_ready = 0; m_err = 0;
        hist.delete();
        repeat (HL-1) hist.push_back(idle_sample());
        hist.push_back(cur);
      end else begin
        // The edge that just happened saw raw non-synced inputs from one
        // cycle ago and bus-side inputs SS cycles older than that.
        raw  = hist[HL-1];
        syn  = hist[1];
        prv  = hist[0];
        live = !raw.prog && !m_prog;
        nd   = live && !syn.oe_n;
        if (m_bus_oe && raw.core) m_err = 1;
        if (raw.ldv && m_ld_ready) begin
          if (raw.lda < DEPTH) m_mem[raw.lda] = raw.ldd;
          else m_err = 1;
        end
        if (nd) begin
          if (m_addr < DEPTH) m_bus_out = m_mem[m_addr];
          else begin m_bus_out = 0; m_err = 1; end
        end
        if (live && prv.we_n && !syn.we_n) begin
          if (m_addr < DEPTH) m_mem[m_addr] = syn.bus;
          else m_err = 1;
        end
        if (live && !prv.outc && syn.outc) m_outq = syn.bus;
        if (live && !prv.latch && syn.latch) m_addr = syn.bus;
        m_bus_oe   = nd;
        m_prog     = raw.prog;
        m_ld_ready = raw.prog;

        check("model_bus_oe",   bif.bus_oe, m_bus_oe);
        check("model_ld_ready", ld_ready,   m_ld_ready);
        check("model_out_q",    out_q,      m_outq);
        check("model_err",      err,        m_err);
        if (m_bus_oe) check("model_bus_out", bif.bus_out, m_bus_out);

        hist.push_back(cur);
        void'(hist.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic latch_addr(input logic [7:0] a);
    bif.bus_in = a;
    step(1);
    bif.latch_clk = 1'b1;
    step(2);
    bif.latch_clk = 1'b0;
    step(SS + 2);
  endtask

  task automatic read_at(input logic [7:0] a, output logic [7:0] d);
    latch_addr(a);
    bif.oe_n = 1'b0;
    step(SS + 2);
    #1 d = bif.bus_out;
    bif.oe_n = 1'b1;
    step(SS + 2);
  endtask

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    prog_en = 1'b1;
    step(1);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    step(1);
    ld_valid = 1'b0; prog_en = 1'b0;
    step(2);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [7:0] d;
    rst_n = 1'b0;
    bif.bus_in = 8'h00; bif.latch_clk = 1'b0; bif.oe_n = 1'b1; bif.we_n = 1'b1;
    bif.out_clk = 1'b0; bif.core_bus_oe = 1'b0;
    prog_en = 1'b0; ld_valid = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;

    step(3);
    #1;
    check("rst_bus_oe",   bif.bus_oe,  0);
    check("rst_bus_out",  bif.bus_out, 0);
    check("rst_out_q",    out_q,       0);
    check("rst_ld_ready", ld_ready,    0);
    check("rst_err",      err,         0);

    rst_n = 1'b1;
    step(1);
    prog_en = 1'b1;
    step(1);
    #1 check("ld_ready_prog", ld_ready, 1);
    for (int a = 0; a < DEPTH; a++) begin
      ld_valid = 1'b1;
      ld_addr  = 8'(a);
      ld_data  = (a == 3) ? 8'h2A : 8'($urandom);
      step(1);
    end
    ld_valid = 1'b0;
    prog_en  = 1'b0;
    step(2);

    // Read latency: bus_oe rises exactly SS+1 clocks after oe_n falls.
    latch_addr(8'h03);
    bif.oe_n = 1'b0;
    step(SS);
    #1 check("drive_not_yet", bif.bus_oe, 0);
    step(1);
    #1 check("drive_on",   bif.bus_oe,  1);
    check("read_mem3",     bif.bus_out, 8'h2A);
    step(2);
    bif.oe_n = 1'b1;
    step(SS);
    #1 check("drive_hold", bif.bus_oe, 1);
    step(1);
    #1 check("drive_off",  bif.bus_oe, 0);

    // Write captured on we_n fall; bus change at we_n rise is ignored.
    latch_addr(8'h05);
    bif.bus_in = 8'h77;
    step(1);
    bif.we_n = 1'b0;
    step(2);
    bif.we_n = 1'b1;
    bif.bus_in = 8'h10;
    step(SS + 2);
    read_at(8'h05, d);
    check("write_mem5", d, 8'h77);

    // Output latch.
    bif.bus_in = 8'h9C;
    step(1);
    bif.out_clk = 1'b1;
    step(2);
    bif.out_clk = 1'b0;
    step(SS + 2);
    #1 check("out_q_9c", out_q, 8'h9C);
    read_at(8'h03, d);
    check("out_keeps_mem3", d, 8'h2A);
    read_at(8'h05, d);
    check("out_keeps_mem5", d, 8'h77);

    // Random traffic, all addresses in range and no contention.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) bif.bus_in = 8'($urandom_range(0, DEPTH-1));
      if ($urandom_range(0, 3) == 0) bif.latch_clk = ~bif.latch_clk;
      if ($urandom_range(0, 4) == 0) bif.oe_n = ~bif.oe_n;
      if ($urandom_range(0, 3) == 0) bif.we_n = ~bif.we_n;
      if ($urandom_range(0, 3) == 0) bif.out_clk = ~bif.out_clk;
      if ($urandom_range(0, 39) == 0) prog_en = ~prog_en;
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr  = 8'($urandom_range(0, DEPTH-1));
      ld_data  = 8'($urandom);
      step(1);
    end
    bif.latch_clk = 1'b0; bif.oe_n = 1'b1; bif.we_n = 1'b1; bif.out_clk = 1'b0;
    ld_valid = 1'b0; prog_en = 1'b0;
    step(SS + 3);
    #1 check("random_no_err", err, 0);
    load_byte(8'h03, 8'h2A);

    // Out-of-range read.
    read_at(8'h40, d);
    check("oor_read_data", d, 8'h00);
    check("oor_read_err",  err, 1);
    step(20);
    #1 check("err_sticky", err, 1);
    pulse_reset();
    #1 check("err_cleared", err, 0);

    // Contention.
    latch_addr(8'h03);
    bif.oe_n = 1'b0;
    step(SS + 2);
    bif.core_bus_oe = 1'b1;
    step(1);
    #1 check("contention_err", err, 1);
    bif.core_bus_oe = 1'b0;
    bif.oe_n = 1'b1;
    step(SS + 2);
    pulse_reset();

    // Reset in the middle of a read.
    latch_addr(8'h03);
    bif.oe_n = 1'b0;
    step(SS + 2);
    #1 check("pre_rst_drive", bif.bus_oe, 1);
    rst_n = 1'b0;
    #1 check("rst_async_oe", bif.bus_oe, 0);
    bif.oe_n = 1'b1;
    bif.bus_in = 8'h5A;
    step(2);
    rst_n = 1'b1;
    step(8);
    #1 check("post_rst_out_q", out_q, 0);
    check("post_rst_err", err, 0);
    read_at(8'h03, d);
    check("post_rst_mem3", d, 8'h2A);

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
